// File: rtl/microwave_ctrl.sv
// microwave_ctrl: cooking-time controller for the microwave.
// Shifts encoder digits into a BCD MM:SS register, sequences
// IDLE/COOK/PAUSE/DONE, counts down on the 1 Hz tick and gates the magnetron.
// Optional build macro KEY_SYNC_EN: adds 2-flop synchronizers on the
// encoder, button and door inputs ahead of edge detection.
module microwave_ctrl #(
  parameter int unsigned DONE_HOLD = 5
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       tick,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_COOK  = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [3:0] HOLD_LAST = 4'(DONE_HOLD - 1);

  logic pgt_i, loadn_i, startn_i, stopn_i, door_i;

`ifdef KEY_SYNC_EN
  logic [1:0] pgt_sync, loadn_sync, startn_sync, stopn_sync, door_sync;

  // Two-flop synchronizers, reset to the inactive level of each input
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      pgt_sync    <= 2'b00;
      loadn_sync  <= 2'b11;
      startn_sync <= 2'b11;
      stopn_sync  <= 2'b11;
      door_sync   <= 2'b00;
    end else begin
      pgt_sync    <= {pgt_sync[0], pgt};
      loadn_sync  <= {loadn_sync[0], loadn};
      startn_sync <= {startn_sync[0], startn};
      stopn_sync  <= {stopn_sync[0], stopn};
      door_sync   <= {door_sync[0], door_closed};
    end
  end

  assign pgt_i    = pgt_sync[1];
  assign loadn_i  = loadn_sync[1];
  assign startn_i = startn_sync[1];
  assign stopn_i  = stopn_sync[1];
  assign door_i   = door_sync[1];
`else
  assign pgt_i    = pgt;
  assign loadn_i  = loadn;
  assign startn_i = startn;
  assign stopn_i  = stopn;
  assign door_i   = door_closed;
`endif

  logic        pgt_q, startn_q, stopn_q;
  logic        digit_ev, start_ev, stop_ev;
  logic [15:0] cook_time, time_nxt, time_dec;
  logic [1:0]  state_nxt;
  logic [3:0]  hold_cnt, hold_nxt;

  // BCD countdown with borrow; seconds-tens above 5 simply count down linearly
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign digit_ev = pgt_i & ~pgt_q & ~loadn_i;
  assign start_ev = ~startn_i & startn_q;
  assign stop_ev  = ~stopn_i & stopn_q;
  assign time_dec = bcd_dec(cook_time);

  // Next state, time and hold count; stop > door open > start > tick > digit
  always_comb begin
    state_nxt = state;
    time_nxt  = cook_time;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (stop_ev) begin
          time_nxt = 16'h0000;
        end else if (start_ev) begin
          if (cook_time != 16'h0000 && door_i) state_nxt = ST_COOK;
        end else if (digit_ev && D <= 4'd9) begin
          time_nxt = {cook_time[11:0], D};
        end
      end
      ST_COOK: begin
        if (stop_ev || !door_i) begin
          state_nxt = ST_PAUSE;
        end else if (tick) begin
          time_nxt = time_dec;
          if (time_dec == 16'h0000) begin
            state_nxt = ST_DONE;
            hold_nxt  = 4'd0;
          end
        end
      end
      ST_PAUSE: begin
        if (stop_ev) begin
          state_nxt = ST_IDLE;
          time_nxt  = 16'h0000;
        end else if (start_ev && door_i) begin
          state_nxt = ST_COOK;
        end
      end
      default: begin
        if (start_ev || stop_ev) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          if (hold_cnt == HOLD_LAST) state_nxt = ST_IDLE;
          else hold_nxt = hold_cnt + 4'd1;
        end
      end
    endcase
  end

  // Edge history, state, time and registered outputs
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      pgt_q     <= 1'b0;
      startn_q  <= 1'b1;
      stopn_q   <= 1'b1;
      state     <= ST_IDLE;
      cook_time <= 16'h0000;
      hold_cnt  <= 4'd0;
      mag_on    <= 1'b0;
      done      <= 1'b0;
    end else begin
      pgt_q     <= pgt_i;
      startn_q  <= startn_i;
      stopn_q   <= stopn_i;
      state     <= state_nxt;
      cook_time <= time_nxt;
      hold_cnt  <= hold_nxt;
      mag_on    <= (state_nxt == ST_COOK);
      done      <= (state_nxt == ST_DONE);
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = cook_time;

endmodule

// File: tb/tb_microwave_ctrl.sv
// tb_microwave_ctrl: directed scenarios plus randomized traffic for
// microwave_ctrl, checked every cycle against a decimal-arithmetic model.
module tb_microwave_ctrl;

  logic       clk = 1'b0;
  logic       clearn;
  logic [3:0] D;
  logic       loadn, pgt, startn, stopn, door_closed, tick;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       mag_on, done;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Reference model: time kept as the decimal number MMSS
  int m_state, m_time, m_hold;
  bit p_pgt, p_startn, p_stopn;

  microwave_ctrl #(.DONE_HOLD(5)) dut (
    .clk(clk), .clearn(clearn), .D(D), .loadn(loadn), .pgt(pgt),
    .startn(startn), .stopn(stopn), .door_closed(door_closed), .tick(tick),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .mag_on(mag_on), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic int dec_time(input int n);
    int mm, ss;
    mm = n / 100;
    ss = n % 100;
    if (ss > 0) return n - 1;
    if (mm > 0) return (mm - 1) * 100 + 59;
    return 0;
  endfunction

  // Behavioural model stepped on the same edges as the DUT
  always @(posedge clk or negedge clearn) begin
    bit ev_digit, ev_start, ev_stop;
    if (!clearn) begin
      m_state = 0; m_time = 0; m_hold = 0;
      p_pgt = 1'b0; p_startn = 1'b1; p_stopn = 1'b1;
    end else begin
      ev_digit = pgt && !p_pgt && !loadn;
      ev_start = !startn && p_startn;
      ev_stop  = !stopn && p_stopn;
      p_pgt = pgt; p_startn = startn; p_stopn = stopn;
      case (m_state)
        0: begin
          if (ev_stop) m_time = 0;
          else if (ev_start) begin
            if (m_time != 0 && door_closed) m_state = 1;
          end else if (ev_digit && D <= 9) m_time = (m_time % 1000) * 10 + int'(D);
        end
        1: begin
          if (ev_stop || !door_closed) m_state = 2;
          else if (tick) begin
            m_time = dec_time(m_time);
            if (m_time == 0) begin m_state = 3; m_hold = 0; end
          end
        end
        2: begin
          if (ev_stop) begin m_state = 0; m_time = 0; end
          else if (ev_start && door_closed) m_state = 1;
        end
        default: begin
          if (ev_start || ev_stop) m_state = 0;
          else if (tick) begin
            m_hold++;
            if (m_hold == 5) m_state = 0;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [21:0] act, exp;
    if (check_en) begin
      act = {state, mag_on, done, min_tens, min_ones, sec_tens, sec_ones};
      exp = {2'(m_state), m_state == 1, m_state == 3, to_bcd(m_time)};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL cycle_model t=%0t actual=%h expected=%h", $time, act, exp);
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic enter_digit(input logic [3:0] d);
    @(negedge clk); D = d; loadn = 1'b0; pgt = 1'b1;
    @(negedge clk); pgt = 1'b0; loadn = 1'b1;
  endtask

  task automatic press_start();
    @(negedge clk); startn = 1'b0;
    @(negedge clk); startn = 1'b1;
  endtask

  task automatic press_stop();
    @(negedge clk); stopn = 1'b0;
    @(negedge clk); stopn = 1'b1;
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    D      = 4'($urandom_range(0, 15));
    loadn  = ($urandom_range(0, 3) == 0);
    pgt    = ($urandom_range(0, 2) == 0);
    startn = ($urandom_range(0, 7) != 0);
    stopn  = ($urandom_range(0, 39) != 0);
    tick   = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 29) == 0) door_closed = ~door_closed;
  endtask

  function automatic logic [15:0] cur_time();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    clearn = 1'b0; D = 4'd0; loadn = 1'b1; pgt = 1'b0;
    startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; tick = 1'b0;
    @(negedge clk);
    check_en = 1'b1;
    check_output("reset_time", 32'(cur_time()), 32'h0000);
    check_output("reset_flags", {29'd0, state, mag_on | done}, 32'd0);
    @(negedge clk); clearn = 1'b1;

    // Digit entry
    enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3); enter_digit(4'd0);
    check_output("entry_1230", 32'(cur_time()), 32'h1230);
    check_output("entry_idle", 32'(state), 32'd0);
    enter_digit(4'd5);
    check_output("entry_2305", 32'(cur_time()), 32'h2305);
    enter_digit(4'd12);
    check_output("entry_bad_digit", 32'(cur_time()), 32'h2305);

    // Short cook to DONE and back to IDLE
    press_stop();
    check_output("stop_clears", 32'(cur_time()), 32'h0000);
    enter_digit(4'd0); enter_digit(4'd0); enter_digit(4'd0); enter_digit(4'd3);
    press_start();
    check_output("start_cook", {30'd0, state == 2'b01, mag_on}, 32'd3);
    pulse_tick();
    check_output("tick_0002", 32'(cur_time()), 32'h0002);
    pulse_tick();
    check_output("tick_0001", 32'(cur_time()), 32'h0001);
    pulse_tick();
    check_output("tick_done", {12'd0, state, mag_on, done, cur_time()}, {12'd0, 2'b11, 1'b0, 1'b1, 16'h0000});
    for (int i = 0; i < 4; i++) pulse_tick();
    check_output("done_hold4", {30'd0, state}, 32'd3);
    pulse_tick();
    check_output("done_exit", {29'd0, state, done}, 32'd0);

    // Borrow across minutes
    enter_digit(4'd0); enter_digit(4'd1); enter_digit(4'd0); enter_digit(4'd0);
    press_start(); pulse_tick();
    check_output("borrow_0059", 32'(cur_time()), 32'h0059);
    press_stop(); press_stop();
    enter_digit(4'd1); enter_digit(4'd0); enter_digit(4'd0); enter_digit(4'd0);
    press_start(); pulse_tick();
    check_output("borrow_0959", 32'(cur_time()), 32'h0959);
    press_stop(); press_stop();

    // Door open with tick, resume, stop from PAUSE
    enter_digit(4'd0); enter_digit(4'd0); enter_digit(4'd1); enter_digit(4'd0);
    press_start();
    @(negedge clk); tick = 1'b1; door_closed = 1'b0;
    @(negedge clk); tick = 1'b0;
    check_output("door_pause", {13'd0, state, mag_on, cur_time()}, {13'd0, 2'b10, 1'b0, 16'h0010});
    door_closed = 1'b1;
    press_start();
    check_output("resume_cook", {30'd0, state}, 32'd1);
    press_stop();
    check_output("stop_pause", {30'd0, state}, 32'd2);
    press_stop();
    check_output("pause_to_idle", {14'd0, state, cur_time()}, 32'h0000);

    // Ignored starts and stop+start together
    press_start();
    check_output("start_zero", {30'd0, state}, 32'd0);
    enter_digit(4'd5);
    door_closed = 1'b0;
    press_start();
    check_output("start_door_open", {30'd0, state}, 32'd0);
    door_closed = 1'b1;
    press_start();
    @(negedge clk); startn = 1'b0; stopn = 1'b0;
    @(negedge clk); startn = 1'b1; stopn = 1'b1;
    check_output("stop_beats_start", {30'd0, state}, 32'd2);
    press_stop();

    // Asynchronous reset mid-cook
    enter_digit(4'd2); enter_digit(4'd0);
    press_start(); pulse_tick();
    @(posedge clk); #2 clearn = 1'b0;
    #1 check_output("async_reset", {13'd0, state, mag_on, cur_time()}, 32'd0);
    @(negedge clk); clearn = 1'b1;

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 4000; i++) apply_stimulus();

    @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
